// File: rtl/leaf_stream_fifo.sv
`default_nettype none
// ============================================================================
// leaf_stream_fifo : valid/ready stream buffer with occupancy count, feeding a
// hierarchy leaf. Optional high-water mark output enabled by LEAF_FIFO_HWM_EN.
// Revision: 1.0
// ============================================================================
module leaf_stream_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
`ifdef LEAF_FIFO_HWM_EN
  output logic [AW:0]       hwm,
`endif
  output logic [AW:0]       count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              push_w, pop_w;

  // Ready comes from registered count only: no pop credit when full.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push_w    = in_valid && in_ready;
  assign pop_w     = out_valid && out_ready;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_w) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_w)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_w && !pop_w)      count_d = count_q + (AW+1)'(1);
      else if (!push_w && pop_w) count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_w && !flush) mem_q[wr_ptr_q] <= in_data;
  end

`ifdef LEAF_FIFO_HWM_EN
  logic [AW:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    if (flush)                hwm_d = '0;
    else if (count_d > hwm_q) hwm_d = count_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hwm_q <= '0;
    else        hwm_q <= hwm_d;
  end

  assign hwm = hwm_q;
`endif

  // Producer must hold its word while stalled; withdrawing valid is tolerated.
  a_stall_data_stable : assert property (
    @(posedge clk) disable iff (!rst_n)
    (in_valid && !in_ready) |=> (!in_valid || $stable(in_data))
  );

endmodule
`default_nettype wire

// File: tb/tb_leaf_stream_fifo.sv
`default_nettype none
// ============================================================================
// tb_leaf_stream_fifo : directed plus randomized stimulus against a queue model.
// Revision: 1.0
// ============================================================================
module tb_leaf_stream_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int AW     = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [AW:0]       count;
`ifdef LEAF_FIFO_HWM_EN
  logic [AW:0]       hwm;
`endif

  leaf_stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef LEAF_FIFO_HWM_EN
    .hwm       (hwm),
`endif
    .count     (count)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mq[$];
  int                mhwm = 0;
  int                n_checks = 0;
  int                n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"},     32'(count),     32'(mq.size()));
    check({tag, ".in_ready"},  32'(in_ready),  32'(mq.size() != DEPTH));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
    check({tag, ".out_data"},  32'(out_data),  (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
`ifdef LEAF_FIFO_HWM_EN
    check({tag, ".hwm"},       32'(hwm),       32'(mhwm));
`endif
  endtask

  // One clock: drive, let the edge happen, advance the model, compare.
  task automatic step(input string tag, input logic v, input logic [DATA_W-1:0] d,
                      input logic r, input logic f);
    bit push, pop;
    in_valid = v; in_data = d; out_ready = r; flush = f;
    @(posedge clk);
    push = v && (mq.size() != DEPTH);
    pop  = r && (mq.size() != 0);
    if (f) begin
      mq.delete();
      mhwm = 0;
    end else begin
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(d);
      if (mq.size() > mhwm) mhwm = mq.size();
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit                stalled;
    logic              v, r, f;
    logic [DATA_W-1:0] d;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
    step("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // Fill to full, then one rejected word
    step("fill0", 1'b1, 8'h11, 1'b0, 1'b0);
    step("fill1", 1'b1, 8'h22, 1'b0, 1'b0);
    step("fill2", 1'b1, 8'h33, 1'b0, 1'b0);
    step("fill3", 1'b1, 8'h44, 1'b0, 1'b0);
    check("full.count", 32'(count), 32'd4);
    step("over", 1'b1, 8'h55, 1'b0, 1'b0);
    check("over.in_ready", 32'(in_ready), 32'd0);
    check("over.head", 32'(out_data), 32'h11);

    // Drain: head sequence 11,22,33,44
    check("drain.h0", 32'(out_data), 32'h11);
    step("drain0", 1'b0, 8'h55, 1'b1, 1'b0);
    check("drain.h1", 32'(out_data), 32'h22);
    step("drain1", 1'b0, 8'h00, 1'b1, 1'b0);
    check("drain.h2", 32'(out_data), 32'h33);
    step("drain2", 1'b0, 8'h00, 1'b1, 1'b0);
    check("drain.h3", 32'(out_data), 32'h44);
    step("drain3", 1'b0, 8'h00, 1'b1, 1'b0);
    check("drain.empty", 32'(count), 32'd0);
    step("empty_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    // Simultaneous push/pop at count 2, across pointer wrap
    step("pp_pre0", 1'b1, 8'hA0, 1'b0, 1'b0);
    step("pp_pre1", 1'b1, 8'hA1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step("pushpop", 1'b1, 8'(8'hB0 + i), 1'b1, 1'b0);
      check("pushpop.count2", 32'(count), 32'd2);
    end
`ifdef LEAF_FIFO_HWM_EN
    check("hwm.before_reset", 32'(hwm), 32'd4);
`endif

    // Asynchronous reset between edges at count 2
    #2;
    rst_n = 1'b0;
    mq.delete();
    mhwm = 0;
    #1;
    check("areset.count", 32'(count), 32'd0);
    check("areset.out_valid", 32'(out_valid), 32'd0);
    check_all("areset");
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all("areset_rel");

    // Full plus pop: entry freed, new word refused that cycle
    for (int i = 0; i < 4; i++) step("refill", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    step("fullpop", 1'b1, 8'h99, 1'b1, 1'b0);
    check("fullpop.count", 32'(count), 32'd3);
    check("fullpop.in_ready", 32'(in_ready), 32'd1);
    check("fullpop.head", 32'(out_data), 32'hC1);

    // Flush with a concurrent push at count 3
    check("flush.pre", 32'(count), 32'd3);
    step("flush", 1'b1, 8'h99, 1'b0, 1'b1);
    check("flush.count", 32'(count), 32'd0);
    check("flush.out_valid", 32'(out_valid), 32'd0);
    step("post_flush", 1'b0, 8'h00, 1'b0, 1'b0);

    // Randomized traffic; a stalled word is held until accepted
    stalled = 1'b0;
    d = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if (!stalled) begin
        v = ($urandom_range(0, 3) != 0);
        d = 8'($urandom);
      end else begin
        v = 1'b1;
      end
      r = ($urandom_range(0, 2) != 0) || (i % 50 > 40);
      if (i % 50 < 8) r = 1'b0;
      f = ($urandom_range(0, 59) == 0);
      stalled = v && (mq.size() == DEPTH);
      step("rand", v, d, r, f);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
